// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the RISC-V pipeline slice.
//   XLEN_DEFAULT : default PC / data width
//   INSTR_W      : instruction word width
//   BUBBLE_VALUE : value driven on stage outputs when no entry is presented
package riscv_pipe_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;
    localparam int BUBBLE_VALUE = 0;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and handshake logic for a single-clock FIFO.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   in_valid, in_ready   : producer handshake
//   out_valid, out_ready : consumer handshake
//   flush                : drop everything, including this cycle's beat
//   push, pop            : qualified write / read strobes for the storage
//   wr_ptr, rd_ptr       : storage indices
//   count                : number of valid entries
module sync_fifo_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    input  logic                       flush,
    output logic                       push,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo_ctrl: DEPTH must be a power of two and at least 2");
    end

    // Flags derive from registered count only, so neither handshake
    // input reaches the opposite side combinationally.
    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: holds fetched pc/instruction pairs in strict
// FIFO order and presents the head to decode, with a bubble when empty.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   in_valid/in_ready         : fetch-side handshake
//   pc_in, instruction_in     : fetched pair
//   flush                     : redirect; discards queued and incoming pairs
//   out_valid/out_ready       : decode-side handshake (out_ready low = stall)
//   pc_out, instruction_out   : head pair, zero when out_valid is low
//   count                     : number of queued pairs
module if_id_queue
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [INSTR_W-1:0]         instruction_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            pc_out,
    output logic [INSTR_W-1:0]         instruction_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = XLEN + INSTR_W;

    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;

    // pc and instruction share one storage word so they cannot drift apart.
    logic [ENTRY_W-1:0] mem [DEPTH];

    sync_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Storage is not reset; stale words are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pc_in, instruction_in};
    end

    assign head            = mem[rd_ptr];
    assign pc_out          = out_valid ? head[ENTRY_W-1:INSTR_W] : XLEN'(BUBBLE_VALUE);
    assign instruction_out = out_valid ? head[INSTR_W-1:0]       : INSTR_W'(BUBBLE_VALUE);

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef logic [XLEN+32-1:0] entry_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc_in;
    logic [31:0]     instruction_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_out;
    logic [31:0]     instruction_out;
    logic [2:0]      count;

    int n_cmp = 0;
    int n_bad = 0;
    entry_t sb[$];

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pc_in           (pc_in),
        .instruction_in  (instruction_in),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .count           (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [XLEN-1:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic drive(input logic iv, input logic [XLEN-1:0] pc,
                         input logic ordy, input logic fl);
        in_valid       = iv;
        pc_in          = pc;
        instruction_in = instr_of(pc);
        out_ready      = ordy;
        flush          = fl;
    endtask

    // Advance one clock, updating the scoreboard from the bench's own
    // view of acceptance (occupancy tracked by sb.size()).
    task automatic advance();
        logic   do_pop;
        logic   do_push;
        entry_t beat;
        do_pop  = (sb.size() != 0) && out_ready && !flush;
        do_push = in_valid && (sb.size() < DEPTH) && !flush;
        beat    = {pc_in, instruction_in};
        @(posedge clk);
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(beat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        advance();
        advance();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        n_cmp++; if (instruction_out !== 32'h0) begin n_bad++; $display("FAIL reset_instr_out: got %h expected 0", instruction_out); end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        instruction_in = 32'h00A00093;
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_cmp++; if (pc_out !== 32'h100) begin n_bad++; $display("FAIL single_pc: got %h expected 100", pc_out); end
        n_cmp++; if (instruction_out !== 32'h00A00093) begin n_bad++; $display("FAIL single_instr: got %h expected 00a00093", instruction_out); end
        n_cmp++; if (sb.size() != 1 || {pc_out, instruction_out} !== sb[0]) begin n_bad++; $display("FAIL single_sb: got %h expected scoreboard head", {pc_out, instruction_out}); end
        advance();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_drain_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            advance();
        end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        advance();
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_fifth_count: got %0d expected 4", count); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL fill_stall_head: got %h expected 0", pc_out); end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || pc_out !== 32'(4 * i) || instruction_out !== instr_of(32'(4 * i))) begin
                n_bad++; $display("FAIL drain_order_%0d: got v=%b pc=%h ins=%h expected pc=%h", i, out_valid, pc_out, instruction_out, 32'(4 * i));
            end
            n_cmp++;
            if (sb.size() == 0 || {pc_out, instruction_out} !== sb[0]) begin
                n_bad++; $display("FAIL drain_sb_%0d: got %h expected scoreboard head", i, {pc_out, instruction_out});
            end
            advance();
        end
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got count=%0d v=%b expected 0/0", count, out_valid); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
            if (i > 0) begin
                n_cmp++;
                if (count !== 3'd1 || pc_out !== 32'h1000 + 32'(4 * (i - 1))) begin
                    n_bad++; $display("FAIL stream_%0d: got count=%0d pc=%h expected 1/%h", i, count, pc_out, 32'h1000 + 32'(4 * (i - 1)));
                end
                n_cmp++;
                if (sb.size() != 1 || {pc_out, instruction_out} !== sb[0]) begin
                    n_bad++; $display("FAIL stream_sb_%0d: got %h expected scoreboard head", i, {pc_out, instruction_out});
                end
            end
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (pc_out !== 32'h1024) begin n_bad++; $display("FAIL stream_last: got %h expected 1024", pc_out); end
        advance();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL stream_empty: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0);
            advance();
        end
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        n_cmp++; if (pc_out !== 32'h0 || instruction_out !== 32'h0) begin n_bad++; $display("FAIL flush_bubble: got %h/%h expected 0/0", pc_out, instruction_out); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b0 || pc_out === 32'h40) begin n_bad++; $display("FAIL flush_dropped_%0d: got v=%b pc=%h expected no output", i, out_valid, pc_out); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h60 + 32'(4 * i), 1'b0, 1'b0);
            advance();
        end
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rmid_pre_count: got %0d expected 2", count); end
        reset = 1'b1;
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        advance();
        reset = 1'b0;
        n_cmp++; if (count !== 3'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_state: got count=%0d rdy=%b expected 0/1", count, in_ready); end
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        advance();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || pc_out !== 32'h200) begin n_bad++; $display("FAIL rmid_first: got v=%b pc=%h expected 1/200", out_valid, pc_out); end
        advance();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h80 + 32'(4 * i), 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 32'h90, 1'b1, 1'b0);
        advance();
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fullpop_count: got %0d expected 3", count); end
        n_cmp++; if (pc_out !== 32'h84) begin n_bad++; $display("FAIL fullpop_head: got %h expected 84", pc_out); end
        drive(1'b1, 32'h90, 1'b0, 1'b0);
        advance();
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fullpop_held: got %0d expected 4", count); end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (sb.size() == 0 || out_valid !== 1'b1 || {pc_out, instruction_out} !== sb[0]) begin
                n_bad++; $display("FAIL fullpop_drain_%0d: got v=%b %h expected scoreboard head", i, out_valid, {pc_out, instruction_out});
            end
            if (i == 3) begin
                n_cmp++; if (pc_out !== 32'h90) begin n_bad++; $display("FAIL fullpop_last: got %h expected 90", pc_out); end
            end
            advance();
        end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL fullpop_empty: got %0d expected 0", count); end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_stream();
        test_flush();
        test_reset_mid();
        test_full_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter XLEN, default 32: width of pc_in/pc_out.
REQ-002 Parameter DEPTH, default 4: number of queued fetch entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  IF presents a fetched pc/instruction pair.
REQ-006 in_ready  output  1  queue can accept a pair this cycle.
REQ-007 pc_in  input  XLEN  fetch PC.
REQ-008 instruction_in  input  32  fetched instruction word.
REQ-009 flush  input  1  discard all queued and incoming entries (branch/jump redirect).
REQ-010 out_valid  output  1  head entry is presented to ID.
REQ-011 out_ready  input  1  ID accepts the head this cycle (low = ID stall).
REQ-012 pc_out  output  XLEN  head PC.
REQ-013 instruction_out  output  32  head instruction.
REQ-014 count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-015 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-016 Ordering SHALL be strict FIFO: pairs leave in acceptance order, with pc and instruction always kept together.
REQ-017 Latency SHALL be one cycle: a pair pushed at edge N is visible on the outputs after edge N.
REQ-018 There SHALL be no combinational path from in_* to out_*, or from out_ready to in_ready.
REQ-019 in_ready SHALL equal (count < DEPTH).
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 When full, in_ready is low and the input SHALL be held by IF, even if a pop occurs that cycle.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push only SHALL increment count; pop only SHALL decrement count.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 without a special case.
REQ-024 A flush asserted at edge N SHALL make count=0 and out_valid=0 after edge N; the beat presented with flush is dropped; flush SHALL override push and pop.
REQ-025 When out_valid=0, pc_out SHALL be 0 and instruction_out SHALL be 0 (bubble).
REQ-026 When out_valid=1, pc_out and instruction_out SHALL equal the head entry and SHALL stay stable while out_ready=0.
REQ-027 count SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-028 While reset=1 at a clock edge, the pointers and count SHALL go to 0, so out_valid=0, in_ready=1, pc_out=0, instruction_out=0.
REQ-029 reset SHALL override flush, push and pop; reset mid-stream SHALL discard all entries.
REQ-030 The storage array SHALL NOT require reset; its contents SHALL be unobservable while the corresponding entries are invalid.

Structure
REQ-031 The shared package riscv_pipe_pkg SHALL hold the XLEN default, the instruction width constant (32) and the bubble value (0).
REQ-032 The pointer, count and flag logic SHALL be one sub-module, sync_fifo_ctrl (parameter DEPTH); the storage array and output muxing SHALL stay in if_id_queue.

Verification
REQ-033 After reset, push 0x100/0x00A00093 at cycle 1 with out_ready=1 -> out_valid=1 at cycle 2 with pc_out=0x100, instruction_out=0x00A00093, then count returns to 0.
REQ-034 With out_ready=0, push 4 pairs (pc 0x0,0x4,0x8,0xC) -> count=4 and in_ready=0; a fifth beat is not accepted; then out_ready=1 -> outputs 0x0,0x4,0x8,0xC on consecutive cycles.
REQ-035 Stream 10 pairs with in_valid=1 and out_ready=1 continuously -> one pair per cycle, count steady at 1, pointers wrap, order preserved.
REQ-036 With count=3, assert flush together with in_valid=1 (pc 0x40) -> after the edge count=0, out_valid=0, outputs 0; pc 0x40 never appears.
REQ-037 With count=2, assert reset for one cycle while pushing -> count=0, in_ready=1; the next push of 0x200 is the first output.
REQ-038 With the queue full, assert in_valid and out_ready in the same cycle -> pop only, count=3, and the held beat is accepted on the next cycle.
